// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and lock state enum
// Used by both the sync generator and the sync receiver so the two never disagree.
package vga_timing_pkg;

    localparam int VGA_COORD_W     = 10;
    localparam int VGA_H_DISPLAY   = 640;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC_POS  = 656;
    localparam int VGA_V_DISPLAY   = 480;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC_POS  = 513;
    localparam int VGA_LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - tick-qualified falling-edge detector for an active-low sync
// The history register idles high so a line held low through reset reads as a fresh edge.
module vga_edge_det (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick_i,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b1;
        end else if (tick_i) begin
            sig_q <= sig_i;
        end
    end

    assign fall_o = tick_i & sig_q & ~sig_i;

endmodule

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: flywheel coordinates, period checks, lock FSM
// Coordinates re-align on every sync fall; lock needs LOCK_FRAMES clean frames after a first unchecked vsync.
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int largo       = VGA_COORD_W,
    parameter int H_DISPLAY   = VGA_H_DISPLAY,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC_POS  = VGA_H_SYNC_POS,
    parameter int V_DISPLAY   = VGA_V_DISPLAY,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC_POS  = VGA_V_SYNC_POS,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             p_tick,
    input  logic             hsync,
    input  logic             vsync,
    output logic [largo-1:0] pixel_x,
    output logic [largo-1:0] pixel_y,
    output logic             video_on,
    output logic             locked,
    output logic             frame_start,
    output logic             sync_err,
    output logic [7:0]       err_count
);

    localparam int LT_W = $clog2(2 * H_TOTAL + 1);
    localparam int FL_W = 10;
    localparam int GF_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

    localparam logic [largo-1:0] X_LAST    = largo'(H_TOTAL - 1);
    localparam logic [largo-1:0] X_RESYNC  = largo'(H_SYNC_POS + 1);
    localparam logic [largo-1:0] X_DISP    = largo'(H_DISPLAY);
    localparam logic [largo-1:0] Y_LAST    = largo'(V_TOTAL - 1);
    localparam logic [largo-1:0] Y_RESYNC  = largo'(V_SYNC_POS);
    localparam logic [largo-1:0] Y_DISP    = largo'(V_DISPLAY);
    localparam logic [LT_W-1:0]  LT_LINE   = LT_W'(H_TOTAL - 1);
    localparam logic [LT_W-1:0]  LT_TO_M1  = LT_W'(2 * H_TOTAL - 1);
    localparam logic [LT_W-1:0]  LT_MAX    = '1;
    localparam logic [FL_W-1:0]  FL_FRAME  = FL_W'(V_TOTAL);
    localparam logic [FL_W-1:0]  FL_MAX    = '1;
    localparam logic [GF_W-1:0]  GF_DONE   = GF_W'(LOCK_FRAMES - 1);

    logic             hs_fall;
    logic             vs_fall;
    logic [largo-1:0] x_q, x_d;
    logic [largo-1:0] y_q, y_d;
    logic [LT_W-1:0]  lt_q, lt_d;
    logic [FL_W-1:0]  fl_q, fl_d;
    logic [GF_W-1:0]  gf_q;
    lock_state_t      state_q;
    logic             sync_err_q;
    logic             frame_start_q;
    logic [7:0]       err_count_q;
    logic             h_wrap;
    logic             line_ok;
    logic             frame_ok;
    logic             timeout;
    logic             bad_evt;
    logic             fs_hit;

    vga_edge_det u_hs_det (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .tick_i (p_tick),
        .sig_i  (hsync),
        .fall_o (hs_fall)
    );

    vga_edge_det u_vs_det (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .tick_i (p_tick),
        .sig_i  (vsync),
        .fall_o (vs_fall)
    );

    always_comb begin
        h_wrap   = p_tick & ~hs_fall & (x_q == X_LAST);
        line_ok  = (lt_q == LT_LINE);
        frame_ok = (fl_q == FL_FRAME);
        // Timeout fires on the single tick where lt would step onto 2*H_TOTAL.
        timeout  = p_tick & ~hs_fall & (lt_q == LT_TO_M1);
        bad_evt  = (hs_fall & ~line_ok) | (vs_fall & ~frame_ok) | timeout;
        fs_hit   = h_wrap & ~vs_fall & (y_q == Y_LAST) & (state_q == LOCKED);

        x_d = x_q;
        if (p_tick) begin
            if (hs_fall) begin
                x_d = X_RESYNC;
            end else if (x_q == X_LAST) begin
                x_d = '0;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        y_d = y_q;
        if (vs_fall) begin
            y_d = Y_RESYNC;
        end else if (h_wrap) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end

        lt_d = lt_q;
        if (hs_fall) begin
            lt_d = '0;
        end else if (p_tick && (lt_q != LT_MAX)) begin
            lt_d = lt_q + 1'b1;
        end

        fl_d = fl_q;
        if (vs_fall) begin
            fl_d = hs_fall ? FL_W'(1) : '0;
        end else if (hs_fall && (fl_q != FL_MAX)) begin
            fl_d = fl_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            lt_q          <= '1;
            fl_q          <= '0;
            gf_q          <= '0;
            state_q       <= SEARCH;
            sync_err_q    <= 1'b0;
            frame_start_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            lt_q          <= lt_d;
            fl_q          <= fl_d;
            sync_err_q    <= 1'b0;
            frame_start_q <= fs_hit;

            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q <= ACQUIRE;
                        gf_q    <= '0;
                    end
                end
                ACQUIRE: begin
                    if (bad_evt) begin
                        state_q    <= SEARCH;
                        sync_err_q <= 1'b1;
                    end else if (vs_fall) begin
                        gf_q <= gf_q + 1'b1;
                        if (gf_q == GF_DONE) begin
                            state_q <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (bad_evt) begin
                        state_q    <= SEARCH;
                        sync_err_q <= 1'b1;
                    end
                end
                default: state_q <= SEARCH;
            endcase

            if (bad_evt && (state_q != SEARCH) && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign locked      = (state_q == LOCKED);
    assign video_on    = locked & (x_q < X_DISP) & (y_q < Y_DISP);
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed bench for vga_sync_rx driven by a scaled-down sync generator
module tb_vga_sync_rx;

    localparam int HD  = 16;
    localparam int HT  = 20;
    localparam int HSP = 17;
    localparam int VD  = 8;
    localparam int VT  = 12;
    localparam int VSP = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gen_rst_n;
    logic       p_tick;
    logic       gen_hs;
    logic       gen_vs;
    logic       manual;
    logic       man_hs;
    logic       man_vs;
    logic       hsync;
    logic       vsync;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [7:0] err_count;

    int gh, gv, gframe, vs_evt;
    int skip_h_frame = -1;
    int skip_v_frame = -1;
    int mask_frame   = -1;
    int checks       = 0;
    int errors       = 0;
    int fs_bad       = 0;
    int err_pulses   = 0;
    int mism, fsn, budget;

    always #10 clk = ~clk;

    assign hsync = manual ? man_hs : gen_hs;
    assign vsync = manual ? man_vs : gen_vs;

    vga_sync_rx #(
        .largo       (10),
        .H_DISPLAY   (HD),
        .H_TOTAL     (HT),
        .H_SYNC_POS  (HSP),
        .V_DISPLAY   (VD),
        .V_TOTAL     (VT),
        .V_SYNC_POS  (VSP),
        .LOCK_FRAMES (2)
    ) dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .p_tick      (p_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err),
        .err_count   (err_count)
    );

    // Reference generator: counters step on ticks, syncs registered every clk from the counts.
    always @(posedge clk) begin
        if (!gen_rst_n) begin
            gh     <= 0;
            gv     <= 0;
            gframe <= 0;
            vs_evt <= 0;
            p_tick <= 1'b0;
            gen_hs <= 1'b1;
            gen_vs <= 1'b1;
        end else begin
            p_tick <= ~p_tick;
            if (p_tick) begin
                if (gh == HT - 1) begin
                    gh <= 0;
                    if (gv == VT - 1) begin
                        gv     <= 0;
                        gframe <= gframe + 1;
                    end else if (gframe == skip_v_frame && gv == 2) begin
                        gv <= 4;
                    end else begin
                        gv <= gv + 1;
                    end
                end else if (gframe == skip_h_frame && gv == 2 && gh == 5) begin
                    gh <= 7;
                end else begin
                    gh <= gh + 1;
                end
                if (gv == VSP && gh == 0) vs_evt <= vs_evt + 1;
            end
            gen_hs <= ~((gh >= HSP && gh <= HSP + 1) && !(gframe == mask_frame && (gv == 3 || gv == 4)));
            gen_vs <= ~(gv >= VSP && gv <= VSP + 1);
        end
    end

    always @(negedge clk) begin
        if (frame_start && !locked) fs_bad <= fs_bad + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_vs(input int n, input string tag);
        int target;
        int cnt;
        target = vs_evt + n;
        cnt = 0;
        while (vs_evt < target && cnt < 2000 * n) begin
            @(negedge clk);
            cnt++;
        end
        if (vs_evt < target) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_err(input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!sync_err && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        if (!sync_err) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic track(input int nfr, input bit exp_lock, output int m, output int fs);
        int target;
        target = gframe + nfr;
        m = 0;
        fs = 0;
        for (int i = 0; i < 5000 && gframe < target; i++) begin
            @(negedge clk);
            if (int'(pixel_x) != gh || int'(pixel_y) != gv || locked != exp_lock ||
                video_on != (exp_lock && gh < HD && gv < VD)) m++;
            if (frame_start) fs++;
        end
        if (gframe < target) m += 1000;
    endtask

    task automatic drive(input logic hs, input logic vs);
        @(negedge clk);
        while (!p_tick) @(negedge clk);
        man_hs = hs;
        man_vs = vs;
        @(negedge clk);
        err_pulses += int'(sync_err);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_x"}, int'(pixel_x), 0);
        check({tag, "_y"}, int'(pixel_y), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_video_on"}, int'(video_on), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_sync_err"}, int'(sync_err), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        gen_rst_n = 1'b0;
        manual    = 1'b0;
        man_hs    = 1'b1;
        man_vs    = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n     = 1'b1;
        gen_rst_n = 1'b1;

        // Initial acquisition: lock exactly at the third vsync fall.
        wait_vs(2, "lock1_pre");
        check("lock1_pre", int'(locked), 0);
        wait_vs(1, "lock1");
        check("lock1", int'(locked), 1);
        check("lock1_err_count", int'(err_count), 0);
        track(3, 1'b1, mism, fsn);
        check("track_coord", mism, 0);
        check("track_frame_start", fsn, 3);

        // 19-tick line.
        skip_h_frame = gframe + 1;
        wait_err("short_line");
        check("short_line_locked", int'(locked), 0);
        check("short_line_err_count", int'(err_count), 1);
        @(negedge clk);
        check("short_line_pulse_width", int'(sync_err), 0);
        wait_vs(2, "relock2_pre");
        check("relock2_pre", int'(locked), 0);
        wait_vs(1, "relock2");
        check("relock2", int'(locked), 1);

        // 11-line frame.
        skip_v_frame = gframe + 1;
        wait_err("short_frame");
        check("short_frame_y", int'(pixel_y), VSP);
        check("short_frame_locked", int'(locked), 0);
        check("short_frame_err_count", int'(err_count), 2);
        wait_vs(2, "relock3_pre");
        check("relock3_pre", int'(locked), 0);
        wait_vs(1, "relock3");
        check("relock3", int'(locked), 1);

        // hsync missing for two lines.
        mask_frame = gframe + 1;
        wait_err("hs_timeout");
        check("hs_timeout_locked", int'(locked), 0);
        check("hs_timeout_err_count", int'(err_count), 3);
        track(1, 1'b0, mism, fsn);
        check("free_run_coord", mism, 0);

        // Asynchronous reset mid-line while locked.
        budget = 0;
        @(negedge clk);
        while (!(int'(pixel_x) == 10 && gv < VD && locked) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("pre_reset_video_on", int'(video_on), 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_vs(2, "relock5_pre");
        check("relock5_pre", int'(locked), 0);
        wait_vs(1, "relock5");
        check("relock5", int'(locked), 1);
        check("relock5_err_count", int'(err_count), 0);
        @(negedge clk);
        check("relock5_x", int'(pixel_x), gh);

        // Hand-driven syncs: timeout, simultaneous events, then an error storm.
        @(negedge clk);
        man_hs = 1'b1;
        man_vs = 1'b1;
        manual = 1'b1;
        repeat (45) drive(1'b1, 1'b1);
        check("man_timeout_err_count", int'(err_count), 1);
        check("man_timeout_locked", int'(locked), 0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        check("dual_event_err_count", int'(err_count), 2);
        err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1);
            drive(1'b1, 1'b0);
            drive(1'b0, 1'b1);
        end
        check("storm_err_count", int'(err_count), 255);
        check("storm_pulses", err_pulses, 300);
        err_pulses = 0;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        check("search_no_err", err_pulses, 0);
        check("search_err_count", int'(err_count), 255);
        check("frame_start_unlocked", fs_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the VGA sync generator: consumes active-low hsync/vsync and the 25 MHz pixel-tick enable.
- Flywheel counters recover pixel_x/pixel_y. Line and frame periods are measured against 640x480@60 timing, and a lock FSM declares when the recovered coordinates are trustworthy.
- Sits on the video capture/monitor path and as an in-system checker on the generator's outputs.

Parameters:
- largo, 10, width of coordinate outputs
- H_DISPLAY, 640, visible pixels per line
- H_TOTAL, 800, ticks per line
- H_SYNC_POS, 656, h count at which hsync asserts
- V_DISPLAY, 480, visible lines
- V_TOTAL, 525, lines per frame
- V_SYNC_POS, 513, v count at which vsync asserts
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clk_in  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- p_tick  in  1  pixel enable, one clk in two, same-domain
- hsync  in  1  horizontal sync, active low, same-domain
- vsync  in  1  vertical sync, active low, same-domain
- pixel_x  out  largo  recovered column
- pixel_y  out  largo  recovered row
- video_on  out  1  locked && pixel_x<H_DISPLAY && pixel_y<V_DISPLAY
- locked  out  1  FSM in LOCKED
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0) while locked
- sync_err  out  1  one-clk pulse on every bad line/frame/timeout while ACQUIRE or LOCKED
- err_count  out  8  saturating count of sync_err pulses

Behaviour:
- One clock domain. rst_n is asynchronous and active-low. All state updates only on cycles with p_tick=1, except that pulses clear the following clk.
- Reset values:
  - pixel_x=0, pixel_y=0
  - hs_d=vs_d=1, line tick counter lt=all-ones, frame line counter fl=0
  - FSM=SEARCH
  - locked=0, video_on=0, frame_start=0, sync_err=0, err_count=0
- Edge detect:
  - hs_fall = p_tick & hs_d & ~hsync; vs_fall likewise.
  - hs_d/vs_d capture inputs on tick cycles.
- H counter (on tick):
  - hs_fall → H_SYNC_POS+1. This matches the generator, whose registered hsync is first seen low while its count is H_SYNC_POS.
  - else at H_TOTAL-1 → 0
  - else +1
- V counter (on tick):
  - vs_fall → V_SYNC_POS, with priority over wrap
  - else, when h wraps: at V_TOTAL-1 → 0, else +1
- Line check (on hs_fall):
  - line_ok = (lt == H_TOTAL-1), then lt←0.
  - Other ticks: lt+1, saturating at all-ones.
  - Timeout = lt reaches 2*H_TOTAL with no hs_fall.
- Frame check (on vs_fall):
  - frame_ok = (fl == V_TOTAL), then fl←0, or fl←1 if hs_fall is simultaneous.
  - Other hs_fall: fl+1, saturating at 1023.
- FSM:
  - SEARCH: vs_fall → ACQUIRE with good-frame count gf=0.
  - ACQUIRE:
    - hs_fall with !line_ok, vs_fall with !frame_ok, or timeout → SEARCH with sync_err.
    - vs_fall with frame_ok → gf+1; at gf+1==LOCK_FRAMES → LOCKED.
  - LOCKED: any bad event or timeout → SEARCH with sync_err. Coordinates keep free-running.
  - A bad hs_fall and a vs_fall in the same tick count as one error.
  - The first vs_fall in SEARCH is not checked.
- err_count: increments per sync_err, sticks at 255. Cleared only by reset.
- Timing outputs:
  - frame_start asserts the clk after the tick where (x,y) wraps to (0,0), locked only.
  - Outputs are registered; video_on and locked are combinational from registered state.
- Mid-operation reset: all outputs return to reset values immediately, asynchronously.

Decomposition:
- Shared package vga_timing_pkg holds the H/V display, total and sync-position constants, so this block and the sync generator share one source of truth.
- Lock state enum (SEARCH, ACQUIRE, LOCKED) also lives in vga_timing_pkg.
- One natural sub-module: vga_edge_det (tick-qualified falling-edge detector), instanced twice.
- The remainder stays flat.

Test Plan:
- Drive from the sync generator with shared p_tick, 3 frames → locked rises at the 3rd vsync fall (2 good frames after the first). After lock, pixel_x/pixel_y equal generator counts every clk, and video_on matches.
- Locked, then one line of 799 ticks (hsync fall one tick early) → sync_err pulse, locked=0, err_count=1. Relock after 3 further vsync falls.
- Frame with 524 lines → sync_err at the vsync fall, FSM to SEARCH.
- hsync held high for 1600 ticks while locked → timeout sync_err, locked=0. Counters keep free-running and wrap at 799/524.
- Reset asserted mid-line with pixel_x=300 → all outputs 0 within the same clk. After release, locked stays 0 until 3 vsync falls.
- 300 injected errors → err_count saturates at 255. frame_start pulses exactly once per frame while locked, with count 0 while unlocked.
